wb_mem_responder: RTL and testbench

// Pipelined Wishbone (B4) responder: a word-addressed memory of 2^AW words

---
 rtl/wb_mem_responder_if.sv | 27 ++
 rtl/wb_mem_responder.sv | 94 +++++++++
 tb/tb_wb_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_responder_if.sv
// Pipelined Wishbone B4 bus bundle between a bench master and the memory responder.
// Handshake: a request transfers in any cycle with cyc && stb && !stall; each transfer gets exactly one ack or err later.
interface wb_mem_responder_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] sel;
   logic          stall;
   logic          ack;
   logic          err;
   logic [DW-1:0] rdata;

   modport master (
      output cyc, stb, we, addr, wdata, sel,
      input  stall, ack, err, rdata
   );

   modport slave (
      input  cyc, stb, we, addr, wdata, sel,
      output stall, ack, err, rdata
   );
endinterface

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 memory responder with fixed ack latency, LFSR stall and one error address.
// Responses travel a LATENCY-deep shift register whose last stage drives the bus outputs directly.
module wb_mem_responder #(
   parameter int            AW        = 5,
   parameter int            DW        = 32,
   parameter int            LATENCY   = 2,
   parameter bit            OPT_STALL = 1'b1,
   parameter logic [AW-1:0] ERR_ADDR  = {AW{1'b1}}
) (
   input  logic               i_clk,
   input  logic               i_reset,
   wb_mem_responder_if.slave  bus
);

   localparam int SW    = DW / 8;
   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0]      mem [DEPTH];
   logic               accept;
   logic               is_err;
   logic               wr_en;
   logic [LATENCY-1:0] pipe_ack;
   logic [LATENCY-1:0] pipe_err;
   logic [DW-1:0]      pipe_data [LATENCY];
   logic [15:0]        lfsr;
   logic               lfsr_fb;
   logic [1:0]         stall_run;
   logic               stall_q;
   logic               stall_next;

   assign accept = bus.cyc && bus.stb && !stall_q;
   assign is_err = (bus.addr == ERR_ADDR);
   assign wr_en  = accept && bus.we && !is_err && !i_reset;

   // Memory contents survive reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         for (int b = 0; b < SW; b++) begin
            if (bus.sel[b]) begin
               mem[bus.addr][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
         end
      end
   end

   // Dropping cyc discards every in-flight response; data stays zero unless a read ack is carried.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pipe_ack <= '0;
         pipe_err <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_data[i] <= '0;
         end
      end else if (!bus.cyc) begin
         pipe_ack <= '0;
         pipe_err <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_ack[0]  <= accept && !is_err;
         pipe_err[0]  <= accept && is_err;
         pipe_data[0] <= (accept && !bus.we && !is_err) ? mem[bus.addr] : '0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_ack[i]  <= pipe_ack[i-1];
            pipe_err[i]  <= pipe_err[i-1];
            pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   assign bus.ack   = pipe_ack[LATENCY-1];
   assign bus.err   = pipe_err[LATENCY-1];
   assign bus.rdata = pipe_data[LATENCY-1];

   // Fibonacci LFSR x^16+x^14+x^13+x^11; a stall run is cut off after three cycles.
   assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign stall_next = OPT_STALL && lfsr[0] && lfsr[1] && (stall_run != 2'd3);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         lfsr      <= 16'hACE1;
         stall_run <= 2'd0;
         stall_q   <= 1'b0;
      end else begin
         lfsr      <= {lfsr_fb, lfsr[15:1]};
         stall_q   <= stall_next;
         stall_run <= stall_next ? stall_run + 2'd1 : 2'd0;
      end
   end

   assign bus.stall = stall_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three configurations share one pipelined master, selected by cur.
// A transaction-level model predicts every response slot and data word of the selected responder.
module tb_wb_mem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int          cur;
   logic        m_cyc, m_stb, m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_sel;

   wb_mem_responder_if #(.AW(5), .DW(32)) bus0 ();
   wb_mem_responder_if #(.AW(5), .DW(32)) bus1 ();
   wb_mem_responder_if #(.AW(5), .DW(32)) bus2 ();

   assign bus0.cyc   = (cur == 0) && m_cyc;
   assign bus0.stb   = (cur == 0) && m_stb;
   assign bus0.we    = m_we;
   assign bus0.addr  = m_addr;
   assign bus0.wdata = m_wdata;
   assign bus0.sel   = m_sel;
   assign bus1.cyc   = (cur == 1) && m_cyc;
   assign bus1.stb   = (cur == 1) && m_stb;
   assign bus1.we    = m_we;
   assign bus1.addr  = m_addr;
   assign bus1.wdata = m_wdata;
   assign bus1.sel   = m_sel;
   assign bus2.cyc   = (cur == 2) && m_cyc;
   assign bus2.stb   = (cur == 2) && m_stb;
   assign bus2.we    = m_we;
   assign bus2.addr  = m_addr;
   assign bus2.wdata = m_wdata;
   assign bus2.sel   = m_sel;

   wb_mem_responder #(.AW(5), .DW(32), .LATENCY(1), .OPT_STALL(1'b0)) dut0 (
      .i_clk(clk), .i_reset(rst), .bus(bus0));
   wb_mem_responder #(.AW(5), .DW(32), .LATENCY(4), .OPT_STALL(1'b0)) dut1 (
      .i_clk(clk), .i_reset(rst), .bus(bus1));
   wb_mem_responder #(.AW(5), .DW(32), .LATENCY(3), .OPT_STALL(1'b1)) dut2 (
      .i_clk(clk), .i_reset(rst), .bus(bus2));

   logic        cur_stall, cur_ack, cur_err;
   logic [31:0] cur_rdata;
   always_comb begin
      cur_stall = bus2.stall;
      cur_ack   = bus2.ack;
      cur_err   = bus2.err;
      cur_rdata = bus2.rdata;
      if (cur == 0) begin
         cur_stall = bus0.stall;
         cur_ack   = bus0.ack;
         cur_err   = bus0.err;
         cur_rdata = bus0.rdata;
      end else if (cur == 1) begin
         cur_stall = bus1.stall;
         cur_ack   = bus1.ack;
         cur_err   = bus1.err;
         cur_rdata = bus1.rdata;
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model: expected queue {due[31:0], err, data[31:0]} ----------------
   logic [64:0] exp_q[$];
   logic [31:0] ref_mem [3][32];
   int          cyc_n = 0;
   int          n_acc = 0;
   int          n_resp = 0;
   int          run2 = 0;
   int          acc_cyc[$];
   int          ack_cyc[$];
   logic [31:0] rd_log[$];
   logic [1:0]  resp_log[$];

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      logic [64:0] h;
      logic [31:0] w;
      logic        e_ack, e_err;
      logic [31:0] e_dat;
      int          lat;
      lat = (cur == 0) ? 1 : (cur == 1) ? 4 : 3;
      chk("stall_off0", 64'(bus0.stall), 64'd0);
      chk("stall_off1", 64'(bus1.stall), 64'd0);
      run2 = bus2.stall ? run2 + 1 : 0;
      chk("stall_run", 64'(run2 <= 3), 64'd1);
      if (rst) begin
         exp_q.delete();
         chk("rst_ack", 64'(cur_ack), 64'd0);
         chk("rst_err", 64'(cur_err), 64'd0);
         chk("rst_data", 64'(cur_rdata), 64'd0);
      end else begin
         e_ack = 1'b0;
         e_err = 1'b0;
         e_dat = 32'd0;
         if (exp_q.size() > 0 && int'(exp_q[0][64:33]) == cyc_n) begin
            h     = exp_q.pop_front();
            e_ack = !h[32];
            e_err = h[32];
            e_dat = h[31:0];
         end
         chk("ack", 64'(cur_ack), 64'(e_ack));
         chk("err", 64'(cur_err), 64'(e_err));
         chk("rdata", 64'(cur_rdata), 64'(e_dat));
         if (cur_ack || cur_err) begin
            n_resp++;
            resp_log.push_back({cur_ack, cur_err});
         end
         if (cur_ack) begin
            ack_cyc.push_back(cyc_n);
            rd_log.push_back(cur_rdata);
         end
         if (!m_cyc) begin
            exp_q.delete();
         end else if (m_stb && !cur_stall) begin
            n_acc++;
            acc_cyc.push_back(cyc_n);
            if (m_addr == 5'h1f) begin
               exp_q.push_back({32'(cyc_n + lat), 1'b1, 32'd0});
            end else if (m_we) begin
               w = ref_mem[cur][m_addr];
               for (int b = 0; b < 4; b++) begin
                  if (m_sel[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
               end
               ref_mem[cur][m_addr] = w;
               exp_q.push_back({32'(cyc_n + lat), 1'b0, 32'd0});
            end else begin
               exp_q.push_back({32'(cyc_n + lat), 1'b0, ref_mem[cur][m_addr]});
            end
         end
      end
   end

   function automatic logic [31:0] qd(input int i);
      return (rd_log.size() > i) ? rd_log[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic int qa(input int i);
      return (ack_cyc.size() > i) ? ack_cyc[i] : -1000;
   endfunction
   function automatic int qacc(input int i);
      return (acc_cyc.size() > i) ? acc_cyc[i] : -2000;
   endfunction
   function automatic logic [1:0] qr(input int i);
      return (resp_log.size() > i) ? resp_log[i] : 2'b11;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic bus_req(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      m_cyc   = 1'b1;
      m_stb   = 1'b1;
      m_we    = we;
      m_addr  = a;
      m_wdata = d;
      m_sel   = s;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (!cur_stall) break;
         if (t > 16) begin
            n_checks++;
            n_err++;
            $display("FAIL req_timeout: stall held %0d cycles, required at most 3", t);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      m_stb = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      idle(6);
      m_cyc = 1'b0;
      idle(2);
   endtask

   task automatic clear_logs();
      acc_cyc.delete();
      ack_cyc.delete();
      rd_log.delete();
      resp_log.delete();
   endtask

   logic [31:0] vals [8];
   int a0, r0;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
      $finish;
   end

   initial begin
      vals = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
               32'h0F0F0F0F, 32'hF0F0F0F0, 32'h13579BDF, 32'h2468ACE0};
      rst = 1'b1; cur = 0;
      m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_sel = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ack0", 64'(bus0.ack), 64'd0);
      chk("reset_data1", 64'(bus1.rdata), 64'd0);
      chk("reset_err2", 64'(bus2.err), 64'd0);
      chk("reset_stall2", 64'(bus2.stall), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      // single write/read, latency 1
      clear_logs();
      bus_req(1'b1, 5'h05, 32'hDEADBEEF, 4'hf);
      bus_req(1'b0, 5'h05, 32'h0, 4'hf);
      drain();
      chk("t1_rdata", 64'(qd(1)), 64'h0000_0000_DEADBEEF);
      chk("t1_latency", 64'(qa(1) - qacc(1)), 64'd1);

      // byte lanes
      clear_logs();
      bus_req(1'b1, 5'h03, 32'h11223344, 4'hf);
      bus_req(1'b1, 5'h03, 32'hAABBCCDD, 4'b0101);
      bus_req(1'b0, 5'h03, 32'h0, 4'hf);
      drain();
      chk("t2_bytes", 64'(qd(2)), 64'h0000_0000_11BB33DD);

      // latency 4, back-to-back reads
      cur = 1;
      idle(1);
      for (int i = 0; i < 8; i++) bus_req(1'b1, 5'(i), vals[i], 4'hf);
      drain();
      clear_logs();
      for (int i = 0; i < 8; i++) bus_req(1'b0, 5'(i), 32'h0, 4'hf);
      drain();
      chk("t3_count", 64'(ack_cyc.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         chk("t3_slot", 64'(qa(i) - qacc(0)), 64'(4 + i));
         chk("t3_data", 64'(qd(i)), 64'(vals[i]));
      end

      // error address inside a burst
      clear_logs();
      bus_req(1'b0, 5'h02, 32'h0, 4'hf);
      bus_req(1'b0, 5'h1f, 32'h0, 4'hf);
      bus_req(1'b0, 5'h04, 32'h0, 4'hf);
      drain();
      chk("t5_resp0", 64'(qr(0)), 64'd2);
      chk("t5_resp1", 64'(qr(1)), 64'd1);
      chk("t5_resp2", 64'(qr(2)), 64'd2);
      chk("t5_d0", 64'(qd(0)), 64'(vals[2]));
      chk("t5_d1", 64'(qd(1)), 64'(vals[4]));
      clear_logs();
      bus_req(1'b1, 5'h1f, 32'hFFFFFFFF, 4'hf);
      bus_req(1'b0, 5'h04, 32'h0, 4'hf);
      drain();
      chk("t5_werr", 64'(qr(0)), 64'd1);
      chk("t5_after", 64'(qd(0)), 64'(vals[4]));

      // random stall soak
      cur = 2;
      idle(1);
      a0 = n_acc; r0 = n_resp;
      for (int i = 0; i < 31; i++) bus_req(1'b1, 5'(i), $urandom, 4'hf);
      for (int i = 0; i < 200; i++)
         bus_req(1'b1, 5'($urandom_range(0, 30)), $urandom, 4'($urandom_range(0, 15)));
      drain();
      clear_logs();
      for (int i = 0; i < 31; i++) bus_req(1'b0, 5'(i), 32'h0, 4'hf);
      drain();
      chk("t4_accepts", 64'(n_acc - a0), 64'd262);
      chk("t4_resp_eq", 64'(n_resp - r0), 64'(n_acc - a0));
      chk("t4_reads", 64'(rd_log.size()), 64'd31);

      // abort by dropping cyc, latency 3
      bus_req(1'b1, 5'h09, 32'h0BADF00D, 4'hf);
      drain();
      r0 = n_resp;
      bus_req(1'b0, 5'h09, 32'h0, 4'hf);
      bus_req(1'b0, 5'h09, 32'h0, 4'hf);
      m_cyc = 1'b0;
      idle(8);
      chk("t6_abort", 64'(n_resp - r0), 64'd0);
      clear_logs();
      bus_req(1'b0, 5'h09, 32'h0, 4'hf);
      drain();
      chk("t6_resume", 64'(qd(0)), 64'h0000_0000_0BADF00D);

      // abort by reset pulse
      r0 = n_resp;
      bus_req(1'b0, 5'h09, 32'h0, 4'hf);
      bus_req(1'b0, 5'h09, 32'h0, 4'hf);
      m_stb = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(8);
      chk("t6_rst_abort", 64'(n_resp - r0), 64'd0);
      clear_logs();
      bus_req(1'b0, 5'h09, 32'h0, 4'hf);
      drain();
      chk("t6_rst_resume", 64'(qd(0)), 64'h0000_0000_0BADF00D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
